dec_hazard_unit: RTL and testbench

DEC_HAZARD_UNIT -- requirements
Module: dec_hazard_unit

---
 rtl/dec_hazard_unit.sv | 148 ++++++++++++++
 tb/tb_dec_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dec_hazard_unit.sv
// rtl/dec_hazard_unit.sv - decode-stage RAW hazard scoreboard and branch flush control
//
// Purpose:
//   Holds one write-pending down-counter per architectural register. The unit
//   stalls decode while any source that is read still has a write in flight.
//   It squashes fetch/decode for FLUSH_CYCLES cycles after a taken branch.
//
// Parameters:
//   REG_INDEX_BIT_WIDTH  register index width (2**N registers)
//   WB_LATENCY           DEC/EXE capture to register-file-visible latency, 1..7
//   FLUSH_CYCLES         squash length after a taken branch, 1..7
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   dec_valid            decode holds a valid instruction
//   dec_src1/2(_used)    source register indices and their read qualifiers
//   dec_dst, dec_reg_wrt_en  destination index and its write qualifier
//   exe_br_taken         taken branch or jump resolved in EXE
//   pc_en, fd_en         PC and FE/DEC buffer enables
//   fd_flush             clears the FE/DEC buffer
//   de_bubble            kills writes of the instruction captured into DEC/EXE
//   stall_cnt            stall-cycle counter (only when STALL_CNT_EN is defined)
//
// Configuration macro: STALL_CNT_EN adds the stall_cnt port and its counter.

module dec_hazard_unit #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int WB_LATENCY          = 3,
  parameter int FLUSH_CYCLES        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
  input  logic                           dec_src1_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
  input  logic                           dec_src2_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst,
  input  logic                           dec_reg_wrt_en,
  input  logic                           exe_br_taken,
`ifdef STALL_CNT_EN
  output logic [31:0]                    stall_cnt,
`endif
  output logic                           pc_en,
  output logic                           fd_en,
  output logic                           fd_flush,
  output logic                           de_bubble
);

  localparam int NREG = 1 << REG_INDEX_BIT_WIDTH;
  localparam int CW   = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0] WB_VAL    = CW'(WB_LATENCY);
  localparam logic [2:0]    FLUSH_VAL = 3'(FLUSH_CYCLES - 1);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [2:0]    flush_cnt_q;
  logic [2:0]    flush_cnt_d;

  logic hazard;
  logic squash;
  logic issue;

  // Sources are checked against the counters as they stand this cycle. An
  // instruction that reads its own destination therefore sees only the
  // older write, not its own. A count of 1 still stalls because the
  // register file has no same-cycle bypass.
  always_comb begin
    hazard = dec_valid &
             ((dec_src1_used & (cnt_q[dec_src1] != '0)) |
              (dec_src2_used & (cnt_q[dec_src2] != '0)));
    squash = exe_br_taken | (flush_cnt_q != 3'd0);
    issue  = dec_valid & ~hazard & ~squash;
  end

  // A squash leaves the scoreboard alone. Older writes are already past
  // decode and still retire.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
    end
    if (issue && dec_reg_wrt_en) begin
      cnt_d[dec_dst] = WB_VAL;
    end

    if (exe_br_taken) begin
      flush_cnt_d = FLUSH_VAL;
    end else if (flush_cnt_q != 3'd0) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end else begin
      flush_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      flush_cnt_q <= 3'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is high, the front end is held. The FE/DEC buffer is flushed
  // and nothing is captured into DEC/EXE.
  always_comb begin
    if (reset) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else begin
      pc_en     = ~hazard | exe_br_taken;
      fd_en     = ~hazard | squash;
      fd_flush  = squash;
      de_bubble = hazard | squash | ~dec_valid;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Only true data stalls are counted. Squashed cycles do not count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !squash && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = reset ? 32'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_dec_hazard_unit.sv
// tb/tb_dec_hazard_unit.sv - scoreboard bench for dec_hazard_unit
module tb_dec_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid = 1'b0;
  logic [3:0] dec_src1 = 4'd0;
  logic       dec_src1_used = 1'b0;
  logic [3:0] dec_src2 = 4'd0;
  logic       dec_src2_used = 1'b0;
  logic [3:0] dec_dst = 4'd0;
  logic       dec_reg_wrt_en = 1'b0;
  logic       exe_br_taken = 1'b0;
  logic       pc_en;
  logic       fd_en;
  logic       fd_flush;
  logic       de_bubble;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  outs;  // {pc_en, fd_en, fd_flush, de_bubble}
    logic [31:0] sc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  dec_hazard_unit #(
    .REG_INDEX_BIT_WIDTH(4),
    .WB_LATENCY(3),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dec_valid(dec_valid),
    .dec_src1(dec_src1),
    .dec_src1_used(dec_src1_used),
    .dec_src2(dec_src2),
    .dec_src2_used(dec_src2_used),
    .dec_dst(dec_dst),
    .dec_reg_wrt_en(dec_reg_wrt_en),
    .exe_br_taken(exe_br_taken),
`ifdef STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .pc_en(pc_en),
    .fd_en(fd_en),
    .fd_flush(fd_flush),
    .de_bubble(de_bubble)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle. Each sample is compared against
  // the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "pc_en",     {31'd0, pc_en},     {31'd0, e.outs[3]});
        check(e.name, "fd_en",     {31'd0, fd_en},     {31'd0, e.outs[2]});
        check(e.name, "fd_flush",  {31'd0, fd_flush},  {31'd0, e.outs[1]});
        check(e.name, "de_bubble", {31'd0, de_bubble}, {31'd0, e.outs[0]});
`ifdef STALL_CNT_EN
        check(e.name, "stall_cnt", stall_cnt, e.sc);
`endif
      end
    end
  end

  // Driver: applies one cycle of inputs and queues the hand-computed response.
  task automatic step(input logic rst, input logic v,
                      input logic [3:0] s1, input logic s1u,
                      input logic [3:0] s2, input logic s2u,
                      input logic [3:0] dst, input logic we, input logic br,
                      input logic [3:0] outs, input int sc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; dec_valid = v;
    dec_src1 = s1; dec_src1_used = s1u;
    dec_src2 = s2; dec_src2_used = s2u;
    dec_dst = dst; dec_reg_wrt_en = we; exe_br_taken = br;
    e.outs = outs; e.sc = sc; e.name = nm;
    exp_q.push_back(e);
  endtask

  localparam logic [3:0] RST   = 4'b0011;
  localparam logic [3:0] ISSUE = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] IDLE  = 4'b1101;

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, "rst0");
    step(1, 1, 3, 1, 0, 0, 3, 1, 1, RST, 0, "rst1");

    // writer r3 then dependent reader: stalls 3 cycles
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, ISSUE, 0, "a_wr");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, STALL, 0, "a_st1");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, STALL, 1, "a_st2");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, STALL, 2, "a_st3");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, ISSUE, 3, "a_iss");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,  3, "a_idle");

    // same sequence, source not used: no stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,   0, "b_rst");
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, ISSUE, 0, "b_wr");
    step(0, 1, 3, 0, 0, 0, 4, 0, 0, ISSUE, 0, "b_iss");

    // branch taken during the stall
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,     0, "c_rst");
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, ISSUE,   0, "c_wr");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, STALL,   0, "c_st1");
    step(0, 1, 3, 1, 0, 0, 4, 0, 1, 4'b1111, 1, "c_br");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, 4'b0111, 1, "c_fl");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, ISSUE,   1, "c_iss");

    // back-to-back writers to r5, reader on src2
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,   0, "d_rst");
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, ISSUE, 0, "d_wr0");
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, ISSUE, 0, "d_wr1");
    step(0, 1, 0, 0, 5, 1, 6, 0, 0, STALL, 0, "d_st1");
    step(0, 1, 0, 0, 5, 1, 6, 0, 0, STALL, 1, "d_st2");
    step(0, 1, 0, 0, 5, 1, 6, 0, 0, STALL, 2, "d_st3");
    step(0, 1, 0, 0, 5, 1, 6, 0, 0, ISSUE, 3, "d_iss");

    // reset in the middle of a stall discards pending writes
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,   0, "e_rst");
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, ISSUE, 0, "e_wr");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, STALL, 0, "e_st1");
    step(1, 1, 3, 1, 0, 0, 4, 0, 0, RST,   0, "e_rstmid");
    step(0, 1, 3, 1, 0, 0, 4, 0, 0, ISSUE, 0, "e_iss");

    // own destination as source: only the older write counts
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,   0, "f_rst");
    step(0, 1, 7, 1, 0, 0, 7, 1, 0, ISSUE, 0, "f_self");
    step(0, 1, 7, 1, 0, 0, 7, 1, 0, STALL, 0, "f_st");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,  1, "f_idle1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,  1, "f_idle2");
    step(0, 1, 7, 1, 0, 0, 1, 0, 0, ISSUE, 1, "f_iss");

    // a branch taken during the flush reloads the flush counter
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST,     0, "g_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 0, "g_br0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 0, "g_br1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, "g_fl");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,    0, "g_done");

    // wait for the monitor to drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    tests_run++;
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
